// File: rtl/washing_machine_prog.sv
// Programmable washing machine controller: fill, optional heat, wash, drain,
// N rinse passes and spin, with phase timeouts, pause/resume, abort and latched fault.
module washing_machine_prog #(
  parameter int TIMER_W       = 16,
  parameter int FILL_TIMEOUT  = 1000,
  parameter int HEAT_TIMEOUT  = 5000,
  parameter int DRAIN_TIMEOUT = 1000,
  parameter int WASH_CYCLES   = 2000,
  parameter int RINSE_CYCLES  = 1000,
  parameter int SPIN_CYCLES   = 1500,
  parameter int RINSE_W       = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hot_wash,
  input  logic [RINSE_W-1:0] rinse_cnt,
  input  logic               pause,
  input  logic               abort,
  input  logic               err_clr,
  input  logic               full,
  input  logic               hot,
  input  logic               empty,
  output logic               heater,
  output logic               valve,
  output logic               motor,
  output logic               pump,
  output logic               door_lock,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [3:0]         phase
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FILL  = 4'd1,
    S_HEAT  = 4'd2,
    S_WASH  = 4'd3,
    S_DRAIN = 4'd4,
    S_RINSE = 4'd5,
    S_SPIN  = 4'd6,
    S_DONE  = 4'd7,
    S_ERROR = 4'd8
  } state_e;

  localparam logic [TIMER_W-1:0] FILL_LAST  = TIMER_W'(FILL_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] HEAT_LAST  = TIMER_W'(HEAT_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DRAIN_LAST = TIMER_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] WASH_LAST  = TIMER_W'(WASH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RINSE_LAST = TIMER_W'(RINSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SPIN_LAST  = TIMER_W'(SPIN_CYCLES - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RINSE_W-1:0] rinse_q, rinse_d;
  logic               rflag_q, rflag_d;
  logic               hotw_q, hotw_d;
  logic               abort_q, abort_d;
  logic               run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      rinse_q <= '0;
      rflag_q <= 1'b0;
      hotw_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rinse_q <= rinse_d;
      rflag_q <= rflag_d;
      hotw_q  <= hotw_d;
      abort_q <= abort_d;
    end
  end

  // Abort outranks pause; pause suppresses timeouts and sensor/timer exits.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rinse_d = rinse_q;
    rflag_d = rflag_q;
    hotw_d  = hotw_q;
    abort_d = abort_q;
    run     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          hotw_d  = hot_wash;
          rinse_d = rinse_cnt;
          rflag_d = 1'b0;
          state_d = S_FILL;
        end
      end
      S_FILL, S_HEAT, S_WASH, S_RINSE, S_SPIN: begin
        if (abort) begin
          abort_d = 1'b1;
          state_d = S_DRAIN;
        end else if (!pause) begin
          run = 1'b1;
          case (state_q)
            S_FILL: begin
              if (timer_q == FILL_LAST && !full) state_d = S_ERROR;
              else if (full) state_d = rflag_q ? S_RINSE : (hotw_q ? S_HEAT : S_WASH);
            end
            S_HEAT: begin
              if (timer_q == HEAT_LAST && !hot) state_d = S_ERROR;
              else if (hot) state_d = S_WASH;
            end
            S_WASH:  if (timer_q == WASH_LAST)  state_d = S_DRAIN;
            S_RINSE: if (timer_q == RINSE_LAST) state_d = S_DRAIN;
            default: if (timer_q == SPIN_LAST)  state_d = S_DONE;
          endcase
        end
      end
      S_DRAIN: begin
        if (abort) abort_d = 1'b1;
        if (!pause) begin
          run = 1'b1;
          if (timer_q == DRAIN_LAST && !empty) begin
            state_d = S_ERROR;
          end else if (empty) begin
            if (abort_q || abort) begin
              state_d = S_IDLE;
            end else if (rinse_q != '0) begin
              rinse_d = rinse_q - RINSE_W'(1);
              rflag_d = 1'b1;
              state_d = S_FILL;
            end else begin
              state_d = S_SPIN;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: if (err_clr && empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) abort_d = 1'b0;
    if (state_d != state_q) timer_d = '0;
    else if (run) timer_d = timer_q + TIMER_W'(1);
  end

  // Moore decode from the state register; pause gates actuators immediately.
  always_comb begin
    heater    = 1'b0;
    valve     = 1'b0;
    motor     = 1'b0;
    pump      = 1'b0;
    door_lock = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state_q)
      S_IDLE:  door_lock = 1'b0;
      S_FILL:  valve  = !pause;
      S_HEAT:  heater = !pause;
      S_WASH,
      S_RINSE: motor  = !pause;
      S_DRAIN: pump   = !pause;
      S_SPIN: begin
        motor = !pause;
        pump  = !pause;
      end
      S_DONE: begin
        door_lock = 1'b0;
        done      = 1'b1;
      end
      S_ERROR: begin
        error     = 1'b1;
        pump      = !empty;
        door_lock = !empty;
      end
      default: door_lock = 1'b0;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign phase = state_q;

endmodule

// File: tb/tb_washing_machine_prog.sv
// Directed bench for washing_machine_prog: expected output vectors are queued as
// stimulus is applied and compared once the DUT has clocked.
module tb_washing_machine_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, hot_wash = 1'b0, pause = 1'b0, abort = 1'b0, err_clr = 1'b0;
  logic       full = 1'b0, hot = 1'b0, empty = 1'b0;
  logic [1:0] rinse_cnt = 2'd0;
  logic       heater, valve, motor, pump, door_lock, busy, done, error;
  logic [3:0] phase;
  logic [11:0] obs;

  int compared = 0;
  int mismatched = 0;
  string       tag_q[$];
  logic [11:0] exp_q[$];

  washing_machine_prog #(
    .TIMER_W(16), .FILL_TIMEOUT(8), .HEAT_TIMEOUT(8), .DRAIN_TIMEOUT(8),
    .WASH_CYCLES(4), .RINSE_CYCLES(3), .SPIN_CYCLES(5), .RINSE_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hot_wash(hot_wash), .rinse_cnt(rinse_cnt),
    .pause(pause), .abort(abort), .err_clr(err_clr), .full(full), .hot(hot), .empty(empty),
    .heater(heater), .valve(valve), .motor(motor), .pump(pump), .door_lock(door_lock),
    .busy(busy), .done(done), .error(error), .phase(phase)
  );

  always #5 clk = ~clk;

  assign obs = {phase, heater, valve, motor, pump, door_lock, busy, done, error};

  // Expected {phase, heater, valve, motor, pump, door_lock, busy, done, error}.
  function automatic logic [11:0] out_for(input int ph);
    logic h, v, m, p, l, b, d, e;
    {h, v, m, p, d, e} = '0;
    l = (ph != 0 && ph != 7);
    b = (ph != 0);
    case (ph)
      1: v = 1'b1;
      2: h = 1'b1;
      3, 5: m = 1'b1;
      4: p = 1'b1;
      6: begin m = 1'b1; p = 1'b1; end
      7: d = 1'b1;
      8: begin e = 1'b1; p = !empty; l = !empty; end
      default: ;
    endcase
    if (pause && ph >= 1 && ph <= 6) {h, v, m, p} = '0;
    return {4'(ph), h, v, m, p, l, b, d, e};
  endfunction

  task automatic check_front();
    string       t;
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      compared++;
      assert (obs === e) else begin
        mismatched++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic step(input string tag, input int ph);
    tag_q.push_back(tag);
    exp_q.push_back(out_for(ph));
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic now(input string tag, input int ph);
    tag_q.push_back(tag);
    exp_q.push_back(out_for(ph));
    #1;
    check_front();
  endtask

  task automatic prog(input logic hw, input logic [1:0] rn);
    hot_wash = hw; rinse_cnt = rn; start = 1'b1;
    step("start_fill", 1);
    start = 1'b0; hot_wash = 1'b0; rinse_cnt = 2'd0;
    step("fill", 1);
    full = 1'b1;
    step("fill_exit", hw ? 2 : 3);
    full = 1'b0;
    if (hw) begin
      step("heat", 2);
      step("heat", 2);
      hot = 1'b1;
      step("heat_exit", 3);
      hot = 1'b0;
    end
    repeat (3) step("wash", 3);
    step("wash_exit", 4);
    step("drain", 4);
    empty = 1'b1;
    step("drain_exit", (rn != 0) ? 1 : 6);
    empty = 1'b0;
    for (int r = 0; r < int'(rn); r++) begin
      step("rfill", 1);
      full = 1'b1;
      step("rfill_exit", 5);
      full = 1'b0;
      repeat (2) step("rinse", 5);
      step("rinse_exit", 4);
      step("rdrain", 4);
      empty = 1'b1;
      step("rdrain_exit", (r == int'(rn) - 1) ? 6 : 1);
      empty = 1'b0;
    end
    repeat (4) step("spin", 6);
    step("done", 7);
    step("idle", 0);
    step("idle_hold", 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    now("reset_state", 0);
    rst_n = 1'b1;
    step("idle_after_reset", 0);

    // Cold program with one rinse, then hot program with none.
    prog(1'b0, 2'd1);
    prog(1'b1, 2'd0);

    // Fill timeout into a latched fault.
    start = 1'b1;
    step("to_start", 1);
    start = 1'b0;
    repeat (7) step("to_fill", 1);
    step("to_error", 8);
    err_clr = 1'b1;
    step("err_clr_wet", 8);
    err_clr = 1'b0; empty = 1'b1;
    step("error_dry", 8);
    err_clr = 1'b1;
    step("err_clr_dry", 0);
    err_clr = 1'b0; empty = 1'b0;
    step("after_err", 0);

    // Pause in WASH after two cycles.
    start = 1'b1;
    step("p_start", 1);
    start = 1'b0; full = 1'b1;
    step("p_wash", 3);
    full = 1'b0;
    step("p_wash", 3);
    step("p_wash", 3);
    pause = 1'b1;
    repeat (10) step("p_paused", 3);
    pause = 1'b0;
    now("p_resume", 3);
    step("p_wash_last", 3);
    step("p_drain", 4);
    empty = 1'b1;
    step("p_spin", 6);
    empty = 1'b0;
    repeat (4) step("p_spin", 6);
    step("p_done", 7);
    step("p_idle", 0);

    // Abort and pause together in SPIN.
    start = 1'b1;
    step("a_start", 1);
    start = 1'b0; full = 1'b1;
    step("a_wash", 3);
    full = 1'b0;
    repeat (3) step("a_wash", 3);
    step("a_drain", 4);
    empty = 1'b1;
    step("a_spin", 6);
    empty = 1'b0;
    step("a_spin", 6);
    abort = 1'b1; pause = 1'b1;
    step("a_abort_drain", 4);
    abort = 1'b0; pause = 1'b0;
    step("a_drain", 4);
    empty = 1'b1;
    step("a_idle_nodone", 0);
    empty = 1'b0;
    step("a_idle_nodone", 0);

    // Asynchronous reset mid-HEAT, then a fresh full program.
    hot_wash = 1'b1; start = 1'b1;
    step("r_start", 1);
    start = 1'b0; hot_wash = 1'b0; full = 1'b1;
    step("r_heat", 2);
    full = 1'b0;
    step("r_heat", 2);
    #3 rst_n = 1'b0;
    now("r_async_reset", 0);
    @(posedge clk);
    #1;
    now("r_held", 0);
    rst_n = 1'b1;
    step("r_idle", 0);
    prog(1'b1, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
